view_scheduler: RTL and testbench
=================================

VIEW_SCHEDULER -- requirements
Module: view_scheduler

Interface
REQ-001 Parameter VIEW_LATENCY, default 4: cycles from forward_view inputs to its pixel output.
REQ-002 Parameter DIVIDER_COLOR, default 12'hFFF: color of the split-screen divider lines.
REQ-003 clk_in  input  1  system clock; one clock domain only.
REQ-004 rst_in  input  1  synchronous, active-low reset.
REQ-005 hcount_in  input  11  pixel column; active 0..1023.
REQ-006 vcount_in  input  10  pixel row; active 0..767.
REQ-007 split_en_in  input  1  1 = two-player split screen, 0 = full-screen player 1.
REQ-008 p1_valid_in / p2_valid_in  input  1  kart state update offered.
REQ-009 p1_x_in, p1_y_in / p2_x_in, p2_y_in  input  11 each  kart map position.
REQ-010 p1_dir_in / p2_dir_in  input  9  kart heading, degrees 0..359.
REQ-011 p1_ready_out / p2_ready_out  output  1  update slot free.
REQ-012 view_hcount_out  output  11  hcount to forward_view.
REQ-013 view_vcount_out  output  10  remapped vcount to forward_view.
REQ-014 direction_out  output  9  viewer heading to forward_view.
REQ-015 player_x_out, player_y_out, opponent_x_out, opponent_y_out  output  11 each  viewer and opponent positions.
REQ-016 view_pixel_in  input  12  forward_view pixel output.
REQ-017 pixel_out  output  12  final screen pixel.
REQ-018 frame_commit_out  output  1  one-cycle pulse when staged state becomes live.

Function
REQ-019 Each player SHALL own a one-entry shadow slot; ready = slot empty; a transfer occurs when valid and ready are both high on a rising edge.
REQ-020 After a transfer, ready SHALL stay low until the next commit; later valids SHALL be ignored, with no overwrite.
REQ-021 The commit SHALL occur on the cycle with hcount_in==0 and vcount_in==768: full slots copied to live registers, slots emptied, split_en_in sampled into split_mode, and frame_commit_out pulsed for that cycle only.
REQ-022 A valid arriving on the commit cycle SHALL be rejected, because ready is low there; ready rises on the following cycle.
REQ-023 The FSM SHALL have states TOP (vcount<384), BOTTOM (384<=vcount<768) and VBLANK (vcount>=768).
  - Transitions SHALL be decoded from vcount_in each cycle.
  - In full mode, BOTTOM SHALL render player 1.
  - vcount wrap 805->0 SHALL enter TOP.
REQ-024 Viewer selection: TOP or full mode = P1 viewing with P2 as opponent; BOTTOM in split mode = P2 viewing with P1 as opponent.
REQ-025 Remapping: split TOP gives view_vcount = vcount<<1; split BOTTOM gives (vcount-384)<<1; full mode passes vcount through; view_hcount = hcount.
REQ-026 All forward_view-facing outputs SHALL be registered, 1 cycle after hcount_in/vcount_in.
REQ-027 A tag {blank, divider} SHALL be computed at the hcount_in/vcount_in sample and delayed VIEW_LATENCY+1 cycles.
  - blank = hcount>=1024 or vcount>=768.
  - divider = split_mode and vcount is 383 or 384.
REQ-028 pixel_out SHALL be registered: 0 if the delayed blank is set, else DIVIDER_COLOR if the delayed divider is set, else view_pixel_in.
  - Total latency from hcount_in to pixel_out = VIEW_LATENCY+2.
REQ-029 split_en_in changes mid-frame SHALL have no effect until the next commit.

Reset
REQ-030 When rst_in is low at a clock edge:
  - slots empty; ready high from the next cycle.
  - live P1 = (1200,191,270); live P2 = (1328,191,270).
  - split_mode = 0; FSM = TOP.
  - tag pipeline cleared to blank.
  - pixel_out = 0; frame_commit_out = 0; view outputs = 0.
REQ-031 A reset mid-frame SHALL discard staged updates, and no commit SHALL be issued until the next vcount==768, hcount==0.

Structure
REQ-032 A shared package view_pkg SHALL hold:
  - the screen constants: H_ACTIVE=1024, V_ACTIVE=768, SPLIT_ROW=384;
  - the reset kart constants;
  - the kart_state_t struct {x, y, dir};
  - the view_state_t enum {TOP, BOTTOM, VBLANK}.
REQ-033 The tag delay SHALL be a sub-module tag_delay, a parameterized shift register of width 2 and depth VIEW_LATENCY+1.

Verification
REQ-034 Reset, then hold idle with split_en_in=0 through to hcount=0, vcount=100:
  - expect direction_out=270, player_x_out=1200, opponent_x_out=1328, view_vcount_out=100 one cycle later.
REQ-035 Split handshake:
  - stimulus: split_en_in=1, P2 offers (500,600,90) mid-frame.
  - expect: p2_ready_out falls next cycle; frame_commit_out pulses at vcount=768, hcount=0.
  - then at hcount=0, vcount=400: player_x_out=500, direction_out=90, opponent_x_out=1200, view_vcount_out=32.
REQ-036 Second offer: P1 offers twice before a commit; expect only the first value live after the commit, and ready high one cycle after the commit.
REQ-037 Valid on commit cycle: P1 valid asserted exactly on the commit cycle; expect it not accepted, and the live state unchanged.
REQ-038 Pixel path: VIEW_LATENCY=4, view_pixel_in=12'h0A5, split mode.
  - at vcount=383: pixel_out=12'hFFF 6 cycles after the sample;
  - at hcount=1100: pixel_out=0;
  - otherwise pixel_out=12'h0A5.
REQ-039 Reset mid-frame: assert rst_in=0 for one cycle at vcount=200 after a P1 offer; expect the slot empty, the live P1 back at its defaults, and pixel_out=0 for 6 cycles.

Source files
------------

// File: rtl/view_pkg.sv
// view_pkg: constants and types shared by the view scheduler and its bench-facing logic.
//   - Screen geometry (active area, split row, divider rows), sized to the counter widths.
//   - Reset kart states for both players.
//   - kart_state_t {x, y, dir} and the view_state_t row-region enum.
package view_pkg;

  localparam logic [10:0] H_ACTIVE        = 11'd1024;
  localparam logic [9:0]  V_ACTIVE        = 10'd768;
  localparam logic [9:0]  SPLIT_ROW       = 10'd384;
  localparam logic [9:0]  DIVIDER_ROW_TOP = 10'd383;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  dir;
  } kart_state_t;

  localparam kart_state_t P1_RESET = '{x: 11'd1200, y: 11'd191, dir: 9'd270};
  localparam kart_state_t P2_RESET = '{x: 11'd1328, y: 11'd191, dir: 9'd270};

  typedef enum logic [1:0] {
    TOP    = 2'd0,
    BOTTOM = 2'd1,
    VBLANK = 2'd2
  } view_state_t;

  // Tag bit order is {blank, divider}; the reset/idle tag is "blank".
  localparam logic [1:0] TAG_BLANK = 2'b10;

endpackage

// File: rtl/tag_delay.sv
// tag_delay: fixed-depth shift register with synchronous active-low reset.
//   clk_in  : clock
//   rst_in  : synchronous active-low reset, loads every stage with RESET_VALUE
//   d_in    : WIDTH-bit value entering the pipe
//   q_out   : value from DEPTH cycles earlier
module tag_delay #(
  parameter int                WIDTH       = 2,
  parameter int                DEPTH       = 5,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_chain
      if (gi == 0) begin : g_head
        assign stage_d[gi] = d_in;
      end else begin : g_body
        assign stage_d[gi] = stage_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/view_scheduler.sv
// view_scheduler: stages per-player kart updates, commits them at the start of
// vertical blank, and drives a forward_view renderer for full or split screen.
//   clk_in, rst_in (sync, active-low)
//   hcount_in/vcount_in      : raster position
//   split_en_in              : split-screen request, sampled only at commit
//   pN_valid_in/pN_ready_out : one-entry update slot handshake per player
//   pN_x_in/pN_y_in/pN_dir_in: offered kart state
//   view_*_out, direction_out, player_*_out, opponent_*_out : registered
//                              forward_view inputs (1 cycle after the raster)
//   view_pixel_in            : forward_view pixel, VIEW_LATENCY after its inputs
//   pixel_out                : final pixel, VIEW_LATENCY+2 after the raster
//   frame_commit_out         : high during the commit cycle
module view_scheduler
  import view_pkg::*;
#(
  parameter int          VIEW_LATENCY  = 4,
  parameter logic [11:0] DIVIDER_COLOR = 12'hFFF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        split_en_in,
  input  logic        p1_valid_in,
  input  logic [10:0] p1_x_in,
  input  logic [10:0] p1_y_in,
  input  logic [8:0]  p1_dir_in,
  output logic        p1_ready_out,
  input  logic        p2_valid_in,
  input  logic [10:0] p2_x_in,
  input  logic [10:0] p2_y_in,
  input  logic [8:0]  p2_dir_in,
  output logic        p2_ready_out,
  output logic [10:0] view_hcount_out,
  output logic [9:0]  view_vcount_out,
  output logic [8:0]  direction_out,
  output logic [10:0] player_x_out,
  output logic [10:0] player_y_out,
  output logic [10:0] opponent_x_out,
  output logic [10:0] opponent_y_out,
  input  logic [11:0] view_pixel_in,
  output logic [11:0] pixel_out,
  output logic        frame_commit_out
);

  // ---------------- update slots and live state ----------------
  logic                   commit;
  logic [1:0]             valid_w;
  kart_state_t [1:0]      offer;
  logic [1:0]             ready;
  logic [1:0]             take;
  logic [1:0]             full_q, full_d;
  kart_state_t [1:0]      slot_q, slot_d;
  kart_state_t [1:0]      live_q, live_d;
  logic                   split_mode_q, split_mode_d;

  // Commit is gated by reset so a reset cycle never reports one.
  assign commit = rst_in && (hcount_in == 11'd0) && (vcount_in == V_ACTIVE);

  assign valid_w  = {p2_valid_in, p1_valid_in};
  assign offer[0] = '{x: p1_x_in, y: p1_y_in, dir: p1_dir_in};
  assign offer[1] = '{x: p2_x_in, y: p2_y_in, dir: p2_dir_in};

  always_comb begin
    ready        = '0;
    take         = '0;
    full_d       = full_q;
    slot_d       = slot_q;
    live_d       = live_q;
    split_mode_d = split_mode_q;
    for (int i = 0; i < 2; i++) begin
      // Ready is forced low on the commit cycle so an update can never
      // race the slot being drained into the live registers.
      ready[i] = !full_q[i] && !commit;
      take[i]  = valid_w[i] && ready[i];
      if (take[i]) begin
        full_d[i] = 1'b1;
        slot_d[i] = offer[i];
      end
      if (commit) begin
        if (full_q[i]) begin
          live_d[i] = slot_q[i];
        end
        full_d[i] = 1'b0;
      end
    end
    if (commit) begin
      split_mode_d = split_en_in;
    end
  end

  assign p1_ready_out     = ready[0];
  assign p2_ready_out     = ready[1];
  assign frame_commit_out = commit;

  // ---------------- row-region FSM ----------------
  view_state_t state_q, state_d;

  // Every transition is decided by the current vcount, so state_d is always
  // the region of the row being sampled; the view outputs use state_d so they
  // land exactly one cycle after the raster.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TOP: begin
        if (vcount_in >= V_ACTIVE)       state_d = VBLANK;
        else if (vcount_in >= SPLIT_ROW) state_d = BOTTOM;
      end
      BOTTOM: begin
        if (vcount_in >= V_ACTIVE)       state_d = VBLANK;
        else if (vcount_in < SPLIT_ROW)  state_d = TOP;
      end
      VBLANK: begin
        if (vcount_in < SPLIT_ROW)       state_d = TOP;
        else if (vcount_in < V_ACTIVE)   state_d = BOTTOM;
      end
      default: state_d = TOP;
    endcase
  end

  // ---------------- forward_view drive ----------------
  logic        view_p2;
  kart_state_t viewer, opponent;
  logic [10:0] view_hcount_q, view_hcount_d;
  logic [9:0]  view_vcount_q, view_vcount_d;
  logic [8:0]  direction_q, direction_d;
  logic [10:0] player_x_q, player_x_d, player_y_q, player_y_d;
  logic [10:0] opponent_x_q, opponent_x_d, opponent_y_q, opponent_y_d;

  always_comb begin
    view_p2  = split_mode_q && (state_d == BOTTOM);
    viewer   = view_p2 ? live_q[1] : live_q[0];
    opponent = view_p2 ? live_q[0] : live_q[1];

    view_hcount_d = hcount_in;
    view_vcount_d = vcount_in;
    if (split_mode_q) begin
      // Each half-screen is rendered at double vertical step so that a
      // 384-row half covers the renderer's full 768-row view.
      unique case (state_d)
        TOP:     view_vcount_d = vcount_in << 1;
        BOTTOM:  view_vcount_d = (vcount_in - SPLIT_ROW) << 1;
        default: view_vcount_d = vcount_in;
      endcase
    end

    direction_d  = viewer.dir;
    player_x_d   = viewer.x;
    player_y_d   = viewer.y;
    opponent_x_d = opponent.x;
    opponent_y_d = opponent.y;
  end

  // ---------------- pixel tag path ----------------
  logic [1:0]  tag_in, tag_out;
  logic [11:0] pixel_q, pixel_d;

  always_comb begin
    tag_in[1] = (hcount_in >= H_ACTIVE) || (vcount_in >= V_ACTIVE);
    tag_in[0] = split_mode_q &&
                ((vcount_in == DIVIDER_ROW_TOP) || (vcount_in == SPLIT_ROW));
  end

  // One extra stage covers the registered view outputs ahead of forward_view.
  tag_delay #(
    .WIDTH       (2),
    .DEPTH       (VIEW_LATENCY + 1),
    .RESET_VALUE (TAG_BLANK)
  ) u_tag_delay (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (tag_in),
    .q_out  (tag_out)
  );

  always_comb begin
    pixel_d = view_pixel_in;
    if (tag_out[1]) begin
      pixel_d = 12'h000;
    end else if (tag_out[0]) begin
      pixel_d = DIVIDER_COLOR;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      full_q        <= '0;
      slot_q        <= '0;
      live_q[0]     <= P1_RESET;
      live_q[1]     <= P2_RESET;
      split_mode_q  <= 1'b0;
      state_q       <= TOP;
      view_hcount_q <= '0;
      view_vcount_q <= '0;
      direction_q   <= '0;
      player_x_q    <= '0;
      player_y_q    <= '0;
      opponent_x_q  <= '0;
      opponent_y_q  <= '0;
      pixel_q       <= '0;
    end else begin
      full_q        <= full_d;
      slot_q        <= slot_d;
      live_q        <= live_d;
      split_mode_q  <= split_mode_d;
      state_q       <= state_d;
      view_hcount_q <= view_hcount_d;
      view_vcount_q <= view_vcount_d;
      direction_q   <= direction_d;
      player_x_q    <= player_x_d;
      player_y_q    <= player_y_d;
      opponent_x_q  <= opponent_x_d;
      opponent_y_q  <= opponent_y_d;
      pixel_q       <= pixel_d;
    end
  end

  assign view_hcount_out = view_hcount_q;
  assign view_vcount_out = view_vcount_q;
  assign direction_out   = direction_q;
  assign player_x_out    = player_x_q;
  assign player_y_out    = player_y_q;
  assign opponent_x_out  = opponent_x_q;
  assign opponent_y_out  = opponent_y_q;
  assign pixel_out       = pixel_q;

endmodule

// File: tb/tb_view_scheduler.sv
// tb_view_scheduler: directed sequences, a vector table and random stimulus,
// all cross-checked every cycle against a behavioural frame/slot model.
module tb_view_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        split_en_in = 1'b0;
  logic        p1_valid_in = 1'b0, p2_valid_in = 1'b0;
  logic [10:0] p1_x_in = '0, p1_y_in = '0, p2_x_in = '0, p2_y_in = '0;
  logic [8:0]  p1_dir_in = '0, p2_dir_in = '0;
  logic        p1_ready_out, p2_ready_out;
  logic [10:0] view_hcount_out;
  logic [9:0]  view_vcount_out;
  logic [8:0]  direction_out;
  logic [10:0] player_x_out, player_y_out, opponent_x_out, opponent_y_out;
  logic [11:0] view_pixel_in = '0;
  logic [11:0] pixel_out;
  logic        frame_commit_out;

  always #5 clk_in = ~clk_in;

  view_scheduler #(.VIEW_LATENCY(4), .DIVIDER_COLOR(12'hFFF)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .split_en_in(split_en_in),
    .p1_valid_in(p1_valid_in), .p1_x_in(p1_x_in), .p1_y_in(p1_y_in),
    .p1_dir_in(p1_dir_in), .p1_ready_out(p1_ready_out),
    .p2_valid_in(p2_valid_in), .p2_x_in(p2_x_in), .p2_y_in(p2_y_in),
    .p2_dir_in(p2_dir_in), .p2_ready_out(p2_ready_out),
    .view_hcount_out(view_hcount_out), .view_vcount_out(view_vcount_out),
    .direction_out(direction_out), .player_x_out(player_x_out),
    .player_y_out(player_y_out), .opponent_x_out(opponent_x_out),
    .opponent_y_out(opponent_y_out), .view_pixel_in(view_pixel_in),
    .pixel_out(pixel_out), .frame_commit_out(frame_commit_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at h=%0d v=%0d",
                  name, act, act, exp, exp, hcount_in, vcount_in);
  endtask

  // ---------------- reference model ----------------
  bit          m_full [2];
  int          m_sx [2], m_sy [2], m_sd [2];       // staged
  int          m_lx [2], m_ly [2], m_ld [2];       // live
  bit          m_split;
  logic [1:0]  tagq [$];                           // {blank, divider}, one per cycle

  // Applies the current inputs for one clock, checks combinational outputs
  // before the edge and registered outputs after it.
  task automatic tick();
    int h, v, vw, e_vv, e_pix;
    int ox [2], oy [2], od [2];
    bit vld [2], rdy [2], commit_e, blank, div;
    logic [1:0] tg;
    int e_dir, e_px, e_py, e_ox, e_oy, e_vh;
    #1;
    h = hcount_in; v = vcount_in;
    vld[0] = p1_valid_in; vld[1] = p2_valid_in;
    ox[0] = p1_x_in; oy[0] = p1_y_in; od[0] = p1_dir_in;
    ox[1] = p2_x_in; oy[1] = p2_y_in; od[1] = p2_dir_in;
    commit_e = rst_in && h == 0 && v == 768;
    for (int p = 0; p < 2; p++) rdy[p] = !m_full[p] && !commit_e;
    check("p1_ready", p1_ready_out, rdy[0]);
    check("p2_ready", p2_ready_out, rdy[1]);
    check("frame_commit", frame_commit_out, commit_e);

    if (rst_in) begin
      vw   = (m_split && v >= 384 && v < 768) ? 1 : 0;
      e_vv = v;
      if (m_split && v < 384) e_vv = 2 * v;
      else if (vw == 1) e_vv = 2 * (v - 384);
      e_vh = h; e_dir = m_ld[vw]; e_px = m_lx[vw]; e_py = m_ly[vw];
      e_ox = m_lx[1-vw]; e_oy = m_ly[1-vw];
      blank = (h >= 1024) || (v >= 768);
      div   = m_split && (v == 383 || v == 384);
      tg = tagq.pop_front();
      e_pix = tg[1] ? 0 : (tg[0] ? 'hFFF : int'(view_pixel_in));
      tagq.push_back({blank, div});
      for (int p = 0; p < 2; p++) begin
        if (vld[p] && rdy[p]) begin
          m_full[p] = 1; m_sx[p] = ox[p]; m_sy[p] = oy[p]; m_sd[p] = od[p];
        end
      end
      if (commit_e) begin
        for (int p = 0; p < 2; p++) begin
          if (m_full[p]) begin m_lx[p] = m_sx[p]; m_ly[p] = m_sy[p]; m_ld[p] = m_sd[p]; end
          m_full[p] = 0;
        end
        m_split = split_en_in;
      end
    end else begin
      e_vv = 0; e_vh = 0; e_dir = 0; e_px = 0; e_py = 0; e_ox = 0; e_oy = 0; e_pix = 0;
      m_full[0] = 0; m_full[1] = 0; m_split = 0;
      m_lx[0] = 1200; m_ly[0] = 191; m_ld[0] = 270;
      m_lx[1] = 1328; m_ly[1] = 191; m_ld[1] = 270;
      tagq.delete();
      repeat (5) tagq.push_back(2'b10);
    end

    @(posedge clk_in); #1;
    check("view_hcount", view_hcount_out, e_vh);
    check("view_vcount", view_vcount_out, e_vv);
    check("direction", direction_out, e_dir);
    check("player_xy", {player_x_out, player_y_out}, {e_px[10:0], e_py[10:0]});
    check("opponent_xy", {opponent_x_out, opponent_y_out}, {e_ox[10:0], e_oy[10:0]});
    check("pixel", pixel_out, e_pix);
  endtask

  task automatic set_hv(input int h, input int v);
    hcount_in = 11'(h); vcount_in = 10'(v);
  endtask

  task automatic offer(input int p, input int x, input int y, input int d);
    if (p == 0) begin p1_valid_in = 1; p1_x_in = 11'(x); p1_y_in = 11'(y); p1_dir_in = 9'(d); end
    else        begin p2_valid_in = 1; p2_x_in = 11'(x); p2_y_in = 11'(y); p2_dir_in = 9'(d); end
  endtask

  typedef struct {
    int h; int v; int e_vv; int e_dir; int e_px; int e_ox;
  } vec_t;
  vec_t tbl [6];

  initial begin
    // Split mode, live P1 = (1200,191,270), live P2 = (500,600,90).
    tbl[0] = '{h: 0,    v: 100, e_vv: 200, e_dir: 270, e_px: 1200, e_ox: 500};
    tbl[1] = '{h: 5,    v: 383, e_vv: 766, e_dir: 270, e_px: 1200, e_ox: 500};
    tbl[2] = '{h: 7,    v: 384, e_vv: 0,   e_dir: 90,  e_px: 500,  e_ox: 1200};
    tbl[3] = '{h: 0,    v: 400, e_vv: 32,  e_dir: 90,  e_px: 500,  e_ox: 1200};
    tbl[4] = '{h: 1023, v: 767, e_vv: 766, e_dir: 90,  e_px: 500,  e_ox: 1200};
    tbl[5] = '{h: 600,  v: 0,   e_vv: 0,   e_dir: 270, e_px: 1200, e_ox: 500};

    // Reset
    repeat (2) @(posedge clk_in);
    #1;
    tick();
    rst_in = 1;
    #1;
    check("ready_after_reset", p1_ready_out, 1);

    // Full-screen idle view
    set_hv(0, 100);
    tick();
    check("full_dir", direction_out, 270);
    check("full_px", player_x_out, 1200);
    check("full_ox", opponent_x_out, 1328);
    check("full_vv", view_vcount_out, 100);

    // Split handshake: P2 stages an update mid-frame
    split_en_in = 1;
    set_hv(10, 50); offer(1, 500, 600, 90);
    tick();
    p2_valid_in = 0; set_hv(11, 50);
    #1;
    check("p2_ready_low", p2_ready_out, 0);
    tick();
    set_hv(0, 768);
    #1;
    check("commit_pulse", frame_commit_out, 1);
    tick();
    set_hv(1, 768);
    #1;
    check("commit_one_cycle", frame_commit_out, 0);
    tick();
    set_hv(0, 400);
    tick();
    check("split_px", player_x_out, 500);
    check("split_dir", direction_out, 90);
    check("split_ox", opponent_x_out, 1200);
    check("split_vv", view_vcount_out, 32);

    // Vector table
    foreach (tbl[i]) begin
      set_hv(tbl[i].h, tbl[i].v);
      tick();
      check("tbl_vv", view_vcount_out, tbl[i].e_vv);
      check("tbl_dir", direction_out, tbl[i].e_dir);
      check("tbl_px", player_x_out, tbl[i].e_px);
      check("tbl_ox", opponent_x_out, tbl[i].e_ox);
      check("tbl_vh", view_hcount_out, tbl[i].h);
    end

    // Two offers before one commit: only the first is kept
    set_hv(2, 20); offer(0, 100, 110, 10);
    tick();
    set_hv(3, 21); offer(0, 200, 210, 20);
    tick();
    p1_valid_in = 0; set_hv(0, 768);
    tick();
    set_hv(1, 768);
    #1;
    check("ready_after_commit", p1_ready_out, 1);
    tick();
    set_hv(0, 10);
    tick();
    check("first_offer_px", player_x_out, 100);
    check("first_offer_dir", direction_out, 10);

    // Valid exactly on the commit cycle is refused
    set_hv(0, 768); offer(0, 300, 310, 30);
    #1;
    check("commit_ready_low", p1_ready_out, 0);
    tick();
    p1_valid_in = 0; set_hv(1, 768);
    #1;
    check("commit_valid_dropped", p1_ready_out, 1);
    tick();
    set_hv(0, 768);
    tick();
    set_hv(0, 10);
    tick();
    check("live_unchanged_px", player_x_out, 100);

    // Pixel path: divider row, blank column, plain pixel
    view_pixel_in = 12'h0A5;
    set_hv(5, 383);
    tick();
    for (int i = 0; i < 5; i++) begin set_hv(10 + i, 100); tick(); end
    check("pix_divider", pixel_out, 12'hFFF);
    set_hv(1100, 100);
    tick();
    for (int i = 0; i < 5; i++) begin set_hv(10 + i, 100); tick(); end
    check("pix_blank", pixel_out, 12'h000);
    set_hv(20, 100);
    tick();
    for (int i = 0; i < 5; i++) begin set_hv(30 + i, 100); tick(); end
    check("pix_plain", pixel_out, 12'h0A5);

    // Reset mid-frame after a staged P1 offer
    set_hv(0, 150); offer(0, 700, 710, 70);
    tick();
    p1_valid_in = 0; set_hv(0, 200); rst_in = 0;
    tick();
    check("rst_pixel_0", pixel_out, 0);
    rst_in = 1; set_hv(0, 100);
    #1;
    check("rst_slot_empty", p1_ready_out, 1);
    for (int i = 1; i < 6; i++) begin
      tick();
      check("rst_pixel", pixel_out, 0);
      if (i == 1) begin
        check("rst_live_px", player_x_out, 1200);
        check("rst_live_dir", direction_out, 270);
      end
    end

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0)      set_hv(0, 768);
      else if (sel == 1) set_hv($urandom_range(0, 1343), $urandom_range(383, 384));
      else               set_hv($urandom_range(0, 1343), $urandom_range(0, 805));
      rst_in        = ($urandom_range(0, 99) != 0);
      split_en_in   = 1'($urandom_range(0, 1));
      view_pixel_in = 12'($urandom);
      p1_valid_in   = 1'($urandom_range(0, 1));
      p2_valid_in   = 1'($urandom_range(0, 1));
      p1_x_in = 11'($urandom); p1_y_in = 11'($urandom); p1_dir_in = 9'($urandom_range(0, 359));
      p2_x_in = 11'($urandom); p2_y_in = 11'($urandom); p2_dir_in = 9'($urandom_range(0, 359));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
